// File: rtl/fetch.sv
// Instruction-byte fetch stage: owns the fetch PC, issues single outstanding byte
// reads, buffers returned bytes in a small FIFO and tracks the CB-prefix state.
module fetch #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        o_valid,
    output logic [7:0]  o_instr,
    output logic [15:0] o_pc,
    output logic        o_is_instr16,
    input  logic        i_ready,
    input  logic        i_is_operand
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] pc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t          state, state_next;
    logic [15:0]     fetch_pc, fetch_pc_next;
    entry_t          fifo_q [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            cb_pending;
    logic            push, pop;

    assign o_valid      = (count != '0);
    assign pop          = o_valid && i_ready;
    // A redirect in the same cycle as the ack throws the returned byte away.
    assign push         = (state == REQ) && mem_ack && !redirect_valid;
    assign count_next   = count + CW'(push) - CW'(pop);

    assign mem_req      = (state != IDLE);
    assign mem_addr     = fetch_pc;
    assign o_instr      = o_valid ? fifo_q[rd_ptr].data : 8'h00;
    assign o_pc         = o_valid ? fifo_q[rd_ptr].pc : 16'h0000;
    assign o_is_instr16 = cb_pending;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (push)
            fetch_pc_next = fetch_pc + 16'd1;
        if (redirect_valid)
            fetch_pc_next = redirect_pc;
        case (state)
            IDLE: begin
                if (!halt && !redirect_valid && (count < CW'(DEPTH)))
                    state_next = REQ;
            end
            REQ: begin
                if (mem_ack)
                    state_next = (!redirect_valid && !halt && (count_next < CW'(DEPTH))) ? REQ : IDLE;
                else if (redirect_valid)
                    state_next = DISCARD;  // read cannot abort; swallow its ack later
            end
            DISCARD: begin
                if (mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= PC_RESET;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cb_pending <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (redirect_valid) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                cb_pending <= 1'b0;
            end else begin
                count <= count_next;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (!i_is_operand)
                        cb_pending <= cb_pending ? 1'b0 : (fifo_q[rd_ptr].data == 8'hCB);
                end
            end
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{data: mem_rdata, pc: fetch_pc};
    end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: memory model with programmable ack delay, FIFO
// back-pressure, CB tracking, redirects, PC wrap and halt.
module tb_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        o_valid;
    logic [7:0]  o_instr;
    logic [15:0] o_pc;
    logic        o_is_instr16;
    logic        i_ready;
    logic        i_is_operand;

    int n_pass = 0;
    int n_chk  = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;

    fetch #(.PC_RESET(16'h0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_is_instr16(o_is_instr16),
        .i_ready(i_ready), .i_is_operand(i_is_operand)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0100: mem_byte = 8'hCB;
            16'h0101: mem_byte = 8'h37;
            16'h0102: mem_byte = 8'hCB;
            16'h0103: mem_byte = 8'h11;
            default:  mem_byte = a[7:0];
        endcase
    endfunction

    // Ack arrives in the (ack_delay+1)-th cycle of a request.
    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_byte(mem_addr);

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!o_valid && n < max) begin
            tick();
            n++;
        end
        chk(tag, 16'(o_valid), 16'd1);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        i_ready = 1'b0; i_is_operand = 1'b0;
        tick(); tick();
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_o_valid", 16'(o_valid), 16'd0);
        chk("rst_o_instr", 16'(o_instr), 16'h0000);
        chk("rst_o_pc", o_pc, 16'h0000);
        chk("rst_cb", 16'(o_is_instr16), 16'd0);

        // Zero-wait streaming with continuous pops
        rst = 1'b0; i_ready = 1'b1;
        tick();
        chk("s_req0", 16'(mem_req), 16'd1);
        chk("s_addr0", mem_addr, 16'h0000);
        chk("s_valid0", 16'(o_valid), 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s_addr", mem_addr, 16'(k + 1));
            chk("s_valid", 16'(o_valid), 16'd1);
            chk("s_instr", 16'(o_instr), 16'(k));
            chk("s_pc", o_pc, 16'(k));
        end

        // Back-pressure: FIFO fills, requests stop, then resume at addr 2
        redirect_valid = 1'b1; redirect_pc = 16'h0000; i_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("bp_flush_valid", 16'(o_valid), 16'd0);
        tick(); tick(); tick(); tick();
        chk("bp_req_stop", 16'(mem_req), 16'd0);
        chk("bp_valid", 16'(o_valid), 16'd1);
        chk("bp_hold_instr", 16'(o_instr), 16'h0000);
        i_ready = 1'b1;
        begin
            int n = 0;
            while (!mem_req && n < 6) begin tick(); n++; end
        end
        chk("bp_resume_req", 16'(mem_req), 16'd1);
        chk("bp_resume_addr", mem_addr, 16'h0002);

        // CB prefix tracking: CB 37 as opcodes, then CB as operand
        redirect_valid = 1'b1; redirect_pc = 16'h0100; i_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("cb_head", 16'(o_instr), 16'h00CB);
        chk("cb_head_pc", o_pc, 16'h0100);
        chk("cb_before", 16'(o_is_instr16), 16'd0);
        i_ready = 1'b1; i_is_operand = 1'b0;
        tick();
        i_ready = 1'b0;
        chk("cb_set_instr", 16'(o_instr), 16'h0037);
        chk("cb_set", 16'(o_is_instr16), 16'd1);
        tick(); tick(); tick(); tick();
        chk("cb_held", 16'(o_is_instr16), 16'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("cb_clear", 16'(o_is_instr16), 16'd0);
        chk("cb_next_head", 16'(o_instr), 16'h00CB);
        tick(); tick(); tick(); tick();
        i_ready = 1'b1; i_is_operand = 1'b1;
        tick();
        i_ready = 1'b0; i_is_operand = 1'b0;
        chk("cb_operand", 16'(o_is_instr16), 16'd0);
        chk("cb_operand_head", 16'(o_instr), 16'h0011);

        // Redirect during a slow read: read completes, data dropped
        redirect_valid = 1'b1; redirect_pc = 16'h0010; ack_delay = 2; i_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("rd_req_rise", 16'(mem_req), 16'd1);
        chk("rd_addr", mem_addr, 16'h0010);
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h4000;
        tick();
        redirect_valid = 1'b0;
        chk("rd_req_held", 16'(mem_req), 16'd1);
        chk("rd_discard_valid", 16'(o_valid), 16'd0);
        tick();
        chk("rd_idle", 16'(mem_req), 16'd0);
        chk("rd_dropped", 16'(o_valid), 16'd0);
        tick();
        chk("rd_new_req", 16'(mem_req), 16'd1);
        chk("rd_new_addr", mem_addr, 16'h4000);
        wait_valid("rd_wait_valid", 10);
        chk("rd_head_pc", o_pc, 16'h4000);
        chk("rd_head_instr", 16'(o_instr), 16'h0000);

        // PC wrap at 16'hFFFF
        ack_delay = 0;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        wait_valid("wr_wait_valid", 10);
        chk("wr_pc0", o_pc, 16'hFFFF);
        chk("wr_instr0", 16'(o_instr), 16'h00FF);
        tick();
        chk("wr_valid1", 16'(o_valid), 16'd1);
        chk("wr_pc1", o_pc, 16'h0000);
        chk("wr_instr1", 16'(o_instr), 16'h0000);

        // Halt during an outstanding 2-cycle read
        redirect_valid = 1'b1; redirect_pc = 16'h0255; i_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; ack_delay = 1;
        tick();
        chk("h_req", 16'(mem_req), 16'd1);
        chk("h_addr", mem_addr, 16'h0255);
        halt = 1'b1;
        tick();
        chk("h_outstanding", 16'(mem_req), 16'd1);
        tick();
        chk("h_buffered_valid", 16'(o_valid), 16'd1);
        chk("h_buffered_instr", 16'(o_instr), 16'h0055);
        chk("h_buffered_pc", o_pc, 16'h0255);
        for (int k = 0; k < 3; k++) begin
            chk("h_no_req", 16'(mem_req), 16'd0);
            tick();
        end
        chk("h_kept", 16'(o_instr), 16'h0055);
        halt = 1'b0;
        tick();
        chk("h_resume_req", 16'(mem_req), 16'd1);
        chk("h_resume_addr", mem_addr, 16'h0256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-byte fetch stage for the sm83 core; sits directly upstream of decode.
- Owns the fetch PC and issues byte reads on the memory bus.
- Buffers returned bytes in a small FIFO and presents them one at a time, with the CB-prefix flag decode consumes as i_is_instr16.
- Control pops opcode and operand bytes from the same stream; jumps, RST and interrupts redirect the stream through a flush.

Parameters:
- PC_RESET, 16'h0000, fetch PC value loaded on reset.
- DEPTH, 2, byte FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- mem_req  out  1  read request; held high until mem_ack.
- mem_addr  out  16  read address; stable while mem_req is high.
- mem_ack  in  1  read accepted and mem_rdata valid in this cycle.
- mem_rdata  in  8  read data.
- redirect_valid  in  1  flush the FIFO and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address.
- halt  in  1  suppress new requests (HALT/STOP).
- o_valid  out  1  FIFO head valid.
- o_instr  out  8  FIFO head byte; to decode instr.
- o_pc  out  16  address of the head byte.
- o_is_instr16  out  1  next opcode byte is the CB second byte; to decode i_is_instr16.
- i_ready  in  1  pop head (effective only when o_valid).
- i_is_operand  in  1  qualifies the pop: 1 = immediate operand byte, 0 = opcode byte.

Behaviour:
- Reset (rst high at a clk edge): state IDLE, FIFO empty, fetch_pc=PC_RESET, cb_pending=0.
  - Outputs: mem_req=0, mem_addr=PC_RESET, o_valid=0, o_instr=8'h00, o_pc=16'h0000, o_is_instr16=0.
  - Reset mid-transaction abandons the outstanding read; no ack is tracked afterwards.
- mem_addr always equals fetch_pc. mem_req=1 exactly in states REQ and DISCARD.
- At most one read outstanding. A read never aborts: mem_req stays high until mem_ack.
- State machine (registered):
  - IDLE -> REQ when !halt && !redirect_valid && count<DEPTH.
  - REQ on mem_ack:
    - If !redirect_valid, write {mem_rdata, fetch_pc} to the FIFO and set fetch_pc += 1 (16-bit wrap: 16'hFFFF -> 16'h0000).
    - Then stay in REQ if !halt && count_next<DEPTH, else go to IDLE.
    - count_next includes this write and any same-cycle pop.
  - REQ with redirect_valid and no ack -> DISCARD; fetch_pc=redirect_pc.
  - REQ with redirect_valid and ack: data dropped; fetch_pc=redirect_pc; -> IDLE.
  - DISCARD: hold mem_req. On mem_ack, drop data and go to IDLE. Further redirects update fetch_pc only.
  - IDLE with redirect_valid: fetch_pc=redirect_pc; stay IDLE for that cycle.
- Redirect, in any state: FIFO flushed (count=0, o_valid=0 next cycle) and cb_pending cleared.
  - Redirect wins over a same-cycle pop or ack.
- Pop: when o_valid && i_ready, the head advances.
  - Write and pop in the same cycle are both honoured.
  - A pop with o_valid=0 is ignored.
- CB tracking, applied on pops with i_is_operand=0 only:
  - If cb_pending=0 and the popped byte is 8'hCB, set cb_pending=1.
  - If cb_pending=1, clear it.
  - o_is_instr16=cb_pending.
  - Operand pops never change cb_pending.
- halt blocks only new requests. An outstanding read completes and its byte is buffered. The FIFO contents are kept.
- Latency and throughput:
  - mem_req rises in the first cycle after rst falls.
  - A byte acked in cycle N is visible on o_valid/o_instr in N+1.
  - With zero-wait acks and continuous pops, throughput is 1 byte/cycle.
  - The FIFO never overflows: requests issue only with count<DEPTH, and count never increases while a read is outstanding.

Test Plan:
- Reset with PC_RESET=0; memory returns addr[7:0], zero-wait ack, i_ready=1 -> mem_addr 0,1,2,3 on consecutive cycles; o_instr 00,01,02 with o_pc matching, one per cycle.
- i_ready=0, zero-wait memory -> two bytes buffered, then mem_req=0 and o_valid=1 holding byte 00; assert i_ready -> fetch resumes at addr 2.
- Byte stream CB 37 pops as opcodes -> o_is_instr16=0 on the pop of CB, 1 while 37 is head, 0 after 37 pops; a CB popped with i_is_operand=1 leaves it 0.
- Memory with 3-cycle ack delay; redirect_pc=16'h4000 one cycle after mem_req rises -> mem_req held until ack; that data never appears; next request at 16'h4000; head o_pc=16'h4000.
- redirect_pc=16'hFFFF, zero-wait memory -> bytes at 16'hFFFF then 16'h0000.
- halt=1 while a 2-cycle read is outstanding -> that byte is buffered; no new mem_req while halt=1; halt=0 -> request at the next address.
